// File: rtl/image_ram_arbiter.sv
// ---------------------------------------------------------------------------
// image_ram_arbiter
//
// Shares the single-port image RAM between the ARM data-memory path (cpu_*)
// and the VGA pixel fetcher (vga_*). One request is granted per cycle and
// issued to the RAM through a registered command stage. Read data returns to
// the requester that issued the read, three cycles after its grant.
//
// Priority: VGA wins over the processor (display deadline). When the macro
// ARB_STARVE_GUARD_EN is defined, a wait counter forces a processor grant
// after MAX_WAIT consecutive denied cycles. When the macro is undefined, VGA
// priority is strict and no wait counter exists.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata    processor request (held until cpu_gnt)
//   cpu_gnt                  combinational grant to the processor
//   cpu_rvalid/cpu_rdata     processor read return (pulse / held data)
//   vga_req/vga_addr         pixel read request (held until vga_gnt)
//   vga_gnt                  combinational grant to the VGA fetcher
//   vga_rvalid/vga_rdata     pixel read return (pulse / held data)
//   ram_addr/wdata/we        registered RAM command
//   ram_rdata                RAM read data, one cycle after ram_addr
//   cpu_stall_cnt            saturating count of denied processor cycles
// ---------------------------------------------------------------------------
module image_ram_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [15:0]       cpu_stall_cnt
);

  typedef enum logic [1:0] {ARB_IDLE, ARB_CPU, ARB_VGA} arb_state_e;

  arb_state_e state_q, state_d;
  logic       guard_fire;
  logic       cpu_denied;

  assign cpu_denied = cpu_req && !cpu_gnt;

  // ---------------------------------------------------------------------
  // Starvation guard
  // ---------------------------------------------------------------------
`ifdef ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;

  // The counter never passes MAX_WAIT: reaching it grants the processor,
  // which clears the counter on the following edge.
  assign guard_fire = (wait_q == WAIT_W'(MAX_WAIT));
  assign wait_d     = cpu_denied ? wait_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wait_q <= '0;
    else      wait_q <= wait_d;
  end
`else
  assign guard_fire = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Owner FSM: state register / next state / grant outputs
  // ---------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ARB_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = ARB_IDLE;
    if (cpu_gnt)      state_d = ARB_CPU;
    else if (vga_gnt) state_d = ARB_VGA;
  end

  // NOTE: every output gets a default before the if-chain; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    cpu_gnt = 1'b0;
    vga_gnt = 1'b0;
    // Grants are masked while reset is asserted so nothing is accepted
    // that the flushed pipeline could not return.
    if (rst) begin
      if (cpu_req && (!vga_req || guard_fire)) cpu_gnt = 1'b1;
      else if (vga_req)                        vga_gnt = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Command stage: loads the winner's fields; idle keeps addr/wdata.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      if (cpu_gnt) begin
        ram_addr  <= cpu_addr;
        ram_wdata <= cpu_wdata;
        ram_we    <= cpu_we;
      end else if (vga_gnt) begin
        ram_addr  <= vga_addr;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read-return pipeline. Stage 1 is the owner state paired with the
  // command currently on the RAM; stage 2 is aligned with ram_rdata.
  // ---------------------------------------------------------------------
  logic s1_vld, s1_cpu;
  logic s2_vld_q, s2_cpu_q;

  assign s1_vld = (state_q != ARB_IDLE) && !ram_we;
  assign s1_cpu = (state_q == ARB_CPU);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vld_q   <= 1'b0;
      s2_cpu_q   <= 1'b0;
      cpu_rvalid <= 1'b0;
      vga_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      vga_rdata  <= '0;
    end else begin
      s2_vld_q   <= s1_vld;
      s2_cpu_q   <= s1_cpu;
      cpu_rvalid <= s2_vld_q && s2_cpu_q;
      vga_rvalid <= s2_vld_q && !s2_cpu_q;
      if (s2_vld_q && s2_cpu_q)  cpu_rdata <= ram_rdata;
      if (s2_vld_q && !s2_cpu_q) vga_rdata <= ram_rdata;
    end
  end

  // ---------------------------------------------------------------------
  // Processor stall statistics, saturating, cleared only by reset.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       cpu_stall_cnt <= '0;
    else if (cpu_denied && cpu_stall_cnt != 16'hFFFF) cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
  end

endmodule
